rf_port_arbiter: RTL and testbench
==================================

# rf_port_arbiter

Arbitrates the single register-file RAM port between the RF load/store engine and the RF move engine. Drives `ram_sel` of the RF RAM mux, grants exclusive ownership to one engine per operation, and releases on that engine's `done`. Round-robin on simultaneous requests, with a programmable dead gap between owners. Also bundles the two engines' `done` pulses into one completion report for the control unit.

## Interface
Parameters:
- `GAP_CYC`, 1: idle cycles inserted between release and the next grant (0 allowed).
- `TIMEOUT_CYC`, 4096: grant-hold cycle limit for the watchdog (ignored without the macro).
- `TMO_W`, 13: width of the watchdog counter; must hold `TIMEOUT_CYC`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ldst_req`  in  1  load/store engine requests the port (level).
- `ldst_gnt`  out  1  load/store engine owns the port.
- `ldst_done`  in  1  load/store operation complete (1-cycle pulse).
- `move_req`  in  1  move engine requests the port (level).
- `move_gnt`  out  1  move engine owns the port.
- `move_done`  in  1  move operation complete (1-cycle pulse).
- `ram_sel`  out  1  RAM mux select: 1 = load/store, 0 = move.
- `busy`  out  1  a grant is active or a gap is running.
- `op_done`  out  1  1-cycle pulse: an owner's operation completed.
- `op_done_src`  out  1  owner of the completed operation (1 = load/store), valid with `op_done`.
- `err_spurious`  out  1  sticky: `done` seen from a non-owner.
- `err_timeout`  out  1  sticky: watchdog forced a release.
- `err_clr`  in  1  clears both sticky error flags.

## Operation
- States: IDLE, OWN_LDST, OWN_MOVE, GAP.
- IDLE, exactly one `*_req` high: go to that engine's OWN state.
- IDLE, both requests high: grant the engine that was not last owner. After reset the last owner is move, so load/store wins the first tie.
- OWN_x: `x_gnt`=1. Requests are ignored. `x_done` goes to GAP, or to IDLE when `GAP_CYC`=0. It pulses `op_done` with `op_done_src`=x and records x as last owner.
- GAP: count down `GAP_CYC` cycles, then IDLE. Requests arriving during GAP are held pending, not lost. Requests are level signals and are re-evaluated in IDLE.
- A request dropped before its grant is simply not granted. No latching in IDLE.
- `ram_sel` changes only on entry to an OWN state. It holds its value through GAP and IDLE, so the mux never toggles without a grant.
- `done` from the non-owner, or in IDLE/GAP: no state change; sets `err_spurious`.
- `done` from the owner in the same cycle as the other engine's request: release wins. The other engine is granted after GAP.
- `err_clr` has priority over a same-cycle set (clear wins).
- `busy` = state ≠ IDLE.

## Timing
- Reset values: state IDLE, `ldst_gnt`=0, `move_gnt`=0, `ram_sel`=0, `busy`=0, `op_done`=0, `op_done_src`=0, both errors 0, last owner = move, gap and watchdog counters 0.
- All outputs are registered.
- Request-to-grant latency: the request is sampled high in IDLE at edge N; `*_gnt` and `ram_sel` are valid after edge N.
- Owner `done` sampled at edge M: after edge M, `*_gnt`=0 and `op_done`=1 for one cycle.
- Earliest next grant: edge M+GAP_CYC+1.
- Back-to-back requests from the same engine with `GAP_CYC`=1: grant-low gap of 2 cycles.
- Reset mid-operation: immediate return to reset values. The engines are reset by the same `rst_n`.

## Configuration
- `RF_ARB_WDT_EN` defined:
  - A counter increments each cycle an OWN state is held and clears on entry to OWN.
  - Reaching `TIMEOUT_CYC` forces a release to GAP and sets `err_timeout`. No `op_done` pulse is issued.
  - Last owner is updated as for a normal release.
- `RF_ARB_WDT_EN` undefined: no counter, `err_timeout` tied 0, `TIMEOUT_CYC`/`TMO_W` unused.

## Structure
- Package `rf_arb_pkg`:
  - `rf_arb_state_e` (IDLE, OWN_LDST, OWN_MOVE, GAP).
  - `rf_owner_e` (OWNER_MOVE=0, OWNER_LDST=1), used for `ram_sel`, `op_done_src` and last owner.
- One sub-module, `rf_arb_wdt`: the watchdog counter (inputs `clk`, `rst_n`, `clr`, `run`; output `expire`). Instantiated only under `RF_ARB_WDT_EN`.

## Test plan
- Reset, then `move_req`=1 at cycle 2 → `move_gnt`=1 and `ram_sel`=0 from cycle 3. `move_done` at cycle 10 → `move_gnt`=0 and `op_done`=1, `op_done_src`=0 at cycle 11.
- Both requests high from reset release → `ldst_gnt` first (`ram_sel`=1). On `ldst_done` with `GAP_CYC`=1, `move_gnt` rises exactly 2 cycles after `ldst_gnt` falls. The next tie grants load/store.
- `ldst_done` pulsed while move owns → `move_gnt` stays 1, `err_spurious`=1. `err_clr` pulse → 0.
- `ldst_req` held 3 cycles during OWN_MOVE, then dropped before release → no load/store grant; returns to IDLE, `busy`=0.
- With `RF_ARB_WDT_EN` and `TIMEOUT_CYC`=16: grant held with no `done` → grant drops after 16 cycles, `err_timeout`=1, no `op_done`.
- `rst_n` asserted mid-grant → `ldst_gnt`/`move_gnt`=0 and `ram_sel`=0 asynchronously. After release, the first tie grants load/store.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file RAM port arbiter: FSM states and the
// owner encoding used for the RAM mux select, completion source and last owner.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_LDST = 2'd1,
        OWN_MOVE = 2'd2,
        GAP      = 2'd3
    } rf_arb_state_e;

    // The owner value doubles as the ram_sel encoding (1 = load/store).
    typedef enum logic {
        OWNER_MOVE = 1'b0,
        OWNER_LDST = 1'b1
    } rf_owner_e;

    function automatic rf_arb_state_e own_state(input rf_owner_e owner);
        return (owner == OWNER_LDST) ? OWN_LDST : OWN_MOVE;
    endfunction

    function automatic rf_owner_e other_owner(input rf_owner_e owner);
        return (owner == OWNER_LDST) ? OWNER_MOVE : OWNER_LDST;
    endfunction

endpackage

// File: rtl/rf_arb_wdt.sv
// Grant-hold watchdog: counts cycles while an owner holds the port and flags
// expiry on the cycle whose edge brings the count up to TIMEOUT_CYC.
module rf_arb_wdt #(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned TMO_W       = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = run && (cnt_q == LIMIT);

endmodule

// File: rtl/rf_port_arbiter.sv
// Round-robin owner of the single RF RAM port shared by the load/store and move
// engines, with a dead gap between owners. Define RF_ARB_WDT_EN for the watchdog.
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned GAP_CYC     = 1,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned TMO_W       = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ldst_req,
    output logic ldst_gnt,
    input  logic ldst_done,
    input  logic move_req,
    output logic move_gnt,
    input  logic move_done,
    output logic ram_sel,
    output logic busy,
    output logic op_done,
    output logic op_done_src,
    output logic err_spurious,
    output logic err_timeout,
    input  logic err_clr
);

    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    if ((TMO_W < 32) && (TIMEOUT_CYC >= (32'd1 << TMO_W))) begin : g_tmo_width_check
        $error("rf_port_arbiter: TMO_W too narrow to hold TIMEOUT_CYC");
    end

    rf_arb_state_e    state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    rf_owner_e        last_q, last_d;
    rf_owner_e        sel_q, sel_d;
    rf_owner_e        src_q, src_d;
    logic             op_done_q, op_done_d;
    logic             err_sp_q, err_sp_d;
    logic             err_to_q, err_to_d;
    logic             ldst_gnt_q, move_gnt_q, busy_q;

    logic             grant_en;
    rf_owner_e        winner;
    rf_owner_e        cur_owner;
    logic             own_done;
    logic             spurious;
    logic             timeout;
    logic             owning;
    logic             wdt_expire;

    assign owning = (state_q == OWN_LDST) || (state_q == OWN_MOVE);

`ifdef RF_ARB_WDT_EN
    rf_arb_wdt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMO_W       (TMO_W)
    ) u_wdt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!owning),
        .run    (owning),
        .expire (wdt_expire)
    );
`else
    assign wdt_expire = 1'b0;
`endif

    // Next-state logic; an owner's own done takes priority over a watchdog expiry.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        last_d    = last_q;
        sel_d     = sel_q;
        src_d     = src_q;
        op_done_d = 1'b0;
        grant_en  = 1'b0;
        winner    = OWNER_LDST;
        cur_owner = (state_q == OWN_LDST) ? OWNER_LDST : OWNER_MOVE;
        own_done  = 1'b0;
        spurious  = 1'b0;
        timeout   = 1'b0;

        case (state_q)
            IDLE: begin
                spurious = ldst_done | move_done;
                if (ldst_req && move_req) begin
                    grant_en = 1'b1;
                    winner   = other_owner(last_q);
                end else if (ldst_req) begin
                    grant_en = 1'b1;
                    winner   = OWNER_LDST;
                end else if (move_req) begin
                    grant_en = 1'b1;
                    winner   = OWNER_MOVE;
                end
                if (grant_en) begin
                    state_d = own_state(winner);
                    sel_d   = winner;
                end
            end

            OWN_LDST, OWN_MOVE: begin
                own_done = (cur_owner == OWNER_LDST) ? ldst_done : move_done;
                spurious = (cur_owner == OWNER_LDST) ? move_done : ldst_done;
                if (own_done || wdt_expire) begin
                    state_d = (GAP_CYC == 0) ? IDLE : GAP;
                    gap_d   = GAP_LOAD;
                    last_d  = cur_owner;
                    timeout = !own_done;
                    if (own_done) begin
                        op_done_d = 1'b1;
                        src_d     = cur_owner;
                    end
                end
            end

            GAP: begin
                spurious = ldst_done | move_done;
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        err_sp_d = err_clr ? 1'b0 : (err_sp_q | spurious);
        err_to_d = err_clr ? 1'b0 : (err_to_q | timeout);
    end

    // Grants and busy are registered from the next state so every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            last_q     <= OWNER_MOVE;
            sel_q      <= OWNER_MOVE;
            src_q      <= OWNER_MOVE;
            op_done_q  <= 1'b0;
            err_sp_q   <= 1'b0;
            err_to_q   <= 1'b0;
            ldst_gnt_q <= 1'b0;
            move_gnt_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            src_q      <= src_d;
            op_done_q  <= op_done_d;
            err_sp_q   <= err_sp_d;
            err_to_q   <= err_to_d;
            ldst_gnt_q <= (state_d == OWN_LDST);
            move_gnt_q <= (state_d == OWN_MOVE);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign ldst_gnt     = ldst_gnt_q;
    assign move_gnt     = move_gnt_q;
    assign ram_sel      = sel_q;
    assign busy         = busy_q;
    assign op_done      = op_done_q;
    assign op_done_src  = src_q;
    assign err_spurious = err_sp_q;
    assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Self-checking bench for rf_port_arbiter: directed scenarios then random
// request/done traffic, all compared every cycle against a behavioural model.
module tb_rf_port_arbiter;

    localparam int GAP = 1;
    localparam int TMO = 16;
`ifdef RF_ARB_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ldst_req = 1'b0, ldst_done = 1'b0;
    logic move_req = 1'b0, move_done = 1'b0;
    logic err_clr = 1'b0;
    logic ldst_gnt, move_gnt, ram_sel, busy, op_done, op_done_src;
    logic err_spurious, err_timeout;

    rf_port_arbiter #(
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TMO),
        .TMO_W       (13)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ldst_req     (ldst_req),
        .ldst_gnt     (ldst_gnt),
        .ldst_done    (ldst_done),
        .move_req     (move_req),
        .move_gnt     (move_gnt),
        .move_done    (move_done),
        .ram_sel      (ram_sel),
        .busy         (busy),
        .op_done      (op_done),
        .op_done_src  (op_done_src),
        .err_spurious (err_spurious),
        .err_timeout  (err_timeout),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner 0 = none, 1 = load/store, 2 = move.
    int m_owner, m_last, m_gap, m_hold;
    bit e_ldst_gnt, e_move_gnt, e_ram_sel, e_busy, e_op_done, e_op_src;
    bit e_err_sp, e_err_to;

    function automatic void model_reset();
        m_owner    = 0;
        m_last     = 2;
        m_gap      = 0;
        m_hold     = 0;
        e_ldst_gnt = 0;
        e_move_gnt = 0;
        e_ram_sel  = 0;
        e_busy     = 0;
        e_op_done  = 0;
        e_op_src   = 0;
        e_err_sp   = 0;
        e_err_to   = 0;
    endfunction

    function automatic void model_step();
        bit sp, to, odone;
        sp = 0;
        to = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        sp = (ldst_done && m_owner != 1) || (move_done && m_owner != 2);
        e_op_done = 0;
        if (m_owner != 0) begin
            odone = (m_owner == 1) ? ldst_done : move_done;
            m_hold++;
            if (odone) begin
                e_op_done = 1;
                e_op_src  = (m_owner == 1);
                m_last    = m_owner;
                m_owner   = 0;
                m_gap     = GAP;
            end else if (WDT_ON && m_hold >= TMO) begin
                to      = 1;
                m_last  = m_owner;
                m_owner = 0;
                m_gap   = GAP;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            if (ldst_req && move_req) m_owner = (m_last == 2) ? 1 : 2;
            else if (ldst_req)        m_owner = 1;
            else if (move_req)        m_owner = 2;
            if (m_owner != 0) begin
                m_hold    = 0;
                e_ram_sel = (m_owner == 1);
            end
        end
        e_err_sp   = err_clr ? 1'b0 : (e_err_sp | sp);
        e_err_to   = err_clr ? 1'b0 : (e_err_to | to);
        e_ldst_gnt = (m_owner == 1);
        e_move_gnt = (m_owner == 2);
        e_busy     = (m_owner != 0) || (m_gap > 0);
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check1("ldst_gnt", ldst_gnt, e_ldst_gnt);
        check1("move_gnt", move_gnt, e_move_gnt);
        check1("ram_sel", ram_sel, e_ram_sel);
        check1("busy", busy, e_busy);
        check1("op_done", op_done, e_op_done);
        if (e_op_done) check1("op_done_src", op_done_src, e_op_src);
        check1("err_spurious", err_spurious, e_err_sp);
        check1("err_timeout", err_timeout, e_err_to);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check after it.
    task automatic applyStimulus(input bit lr, input bit mr, input bit ld,
                                 input bit md, input bit ec);
        ldst_req  = lr;
        move_req  = mr;
        ldst_done = ld;
        move_done = md;
        err_clr   = ec;
        @(posedge clk);
        model_step();
        #1;
        checkOutput();
    endtask

    initial begin
        bit lr, mr, ld, md, ec;
        model_reset();

        $display("[TB] reset values");
        repeat (2) applyStimulus(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] single move request and completion");
        repeat (7) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] tie, release with gap, move follows");
        repeat (4) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        repeat (4) applyStimulus(0, 1, 0, 0, 0);

        $display("[TB] spurious done and clear");
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 1);
        applyStimulus(0, 1, 0, 0, 0);

        $display("[TB] request dropped before grant");
        repeat (3) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] next tie goes to load/store, long hold");
        repeat (TMO + 6) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] asynchronous reset mid-grant");
        repeat (3) applyStimulus(1, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput();
        repeat (2) applyStimulus(1, 1, 0, 0, 0);
        rst_n = 1'b1;
        repeat (3) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        lr = 0;
        mr = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) lr = ~lr;
            if ($urandom_range(0, 3) == 0) mr = ~mr;
            ld = (m_owner == 1 && $urandom_range(0, 4) == 0) || ($urandom_range(0, 49) == 0);
            md = (m_owner == 2 && $urandom_range(0, 4) == 0) || ($urandom_range(0, 49) == 0);
            ec = ($urandom_range(0, 29) == 0);
            applyStimulus(lr, mr, ld, md, ec);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
